// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (D = A - B), LSB first, one bit per clock.
// A single half-subtractor pair and borrow flip-flop are reused for WIDTH cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr, diff_shift;
  logic [CW-1:0]    cnt;
  logic             borrow_ff;
  logic             load, step;
  logic             x, y, d, bo;

  // One full-subtractor stage on the current LSBs
  assign x  = a_sr[0];
  assign y  = b_sr[0];
  assign d  = x ^ y ^ borrow_ff;
  assign bo = (~x & y) | (~(x ^ y) & borrow_ff);

  // New difference bit enters at the MSB; after WIDTH steps the LSB has reached bit 0
  assign diff_shift[WIDTH-1] = d;
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
    assign diff_shift[gi] = diff_sr[gi+1];
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are only sampled on the handshake, so idle-time X on a/b never lands in state
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      diff_sr   <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
    end else if (load) begin
      a_sr      <= a;
      b_sr      <= b;
      borrow_ff <= 1'b0;
      cnt       <= '0;
    end else if (step) begin
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      diff_sr   <= diff_shift;
      borrow_ff <= bo;
      cnt       <= cnt + 1'b1;
    end
  end

  // Both registers are frozen outside RUN, so the result holds through DONE and after it
  assign diff   = diff_sr;
  assign borrow = borrow_ff;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH = 8, 1 and 13.
// Every transaction prints one line; all comparisons go through check().
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [7:0]  a8, b8;
  logic [0:0]  a1, b1;
  logic [12:0] a13, b13;

  logic [2:0]  in_ready, out_valid, borrow, busy;
  logic [7:0]  diff8;
  logic [0:0]  diff1;
  logic [12:0] diff13;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a8), .b(b8), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .diff(diff8), .borrow(borrow[0]), .busy(busy[0]));

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a1), .b(b1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .diff(diff1), .borrow(borrow[1]), .busy(busy[1]));

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a13), .b(b13), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .diff(diff13), .borrow(borrow[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wof(input int sel);
    case (sel)
      0:       return 8;
      1:       return 1;
      default: return 13;
    endcase
  endfunction

  function automatic logic [15:0] rd_diff(input int sel);
    case (sel)
      0:       return {8'b0, diff8};
      1:       return {15'b0, diff1};
      default: return {3'b0, diff13};
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv);
    case (sel)
      0:       begin in_valid[0] = v; a8  = av[7:0];  b8  = bv[7:0];  end
      1:       begin in_valid[1] = v; a1  = av[0:0];  b1  = bv[0:0];  end
      default: begin in_valid[2] = v; a13 = av[12:0]; b13 = bv[12:0]; end
    endcase
  endtask

  // One operation: handshake, latency, result, optional backpressure, result handshake.
  // With probe set, in_valid toggles with foreign operands throughout RUN and DONE.
  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_d, input logic exp_b,
                        input int hold, input bit probe, input string tag);
    int w;
    int cyc;
    w = wof(sel);
    @(negedge clk);
    check({tag, "/in_ready_idle"}, 32'(in_ready[sel]), 32'd1);
    drive(sel, 1'b1, av, bv);
    @(negedge clk);
    drive(sel, 1'b0, av ^ 16'h5555, bv ^ 16'h3333);
    check({tag, "/busy_run"}, 32'(busy[sel]), 32'd1);
    check({tag, "/in_ready_run"}, 32'(in_ready[sel]), 32'd0);
    cyc = 0;
    while (!out_valid[sel] && cyc < 4 * w + 20) begin
      if (probe) drive(sel, cyc[0], av ^ 16'h00A5, bv ^ 16'h005A);
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'(w));
    check({tag, "/diff"}, 32'(rd_diff(sel)), 32'(exp_d));
    check({tag, "/borrow"}, 32'(borrow[sel]), 32'(exp_b));
    for (int h = 0; h < hold; h++) begin
      if (probe) begin
        drive(sel, 1'b1, av ^ 16'h0F0F, bv ^ 16'h00FF);
        check({tag, "/in_ready_done"}, 32'(in_ready[sel]), 32'd0);
      end
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(out_valid[sel]), 32'd1);
      check({tag, "/hold_diff"}, 32'(rd_diff(sel)), 32'(exp_d));
      check({tag, "/hold_borrow"}, 32'(borrow[sel]), 32'(exp_b));
    end
    drive(sel, 1'b0, av, bv);
    out_ready[sel] = 1'b1;
    @(negedge clk);
    out_ready[sel] = 1'b0;
    check({tag, "/valid_drop"}, 32'(out_valid[sel]), 32'd0);
    check({tag, "/in_ready_back"}, 32'(in_ready[sel]), 32'd1);
    check({tag, "/busy_idle"}, 32'(busy[sel]), 32'd0);
    $display("op %s w=%0d a=0x%0h b=0x%0h diff=0x%0h borrow=%0b lat=%0d hold=%0d",
             tag, w, av, bv, exp_d, exp_b, cyc, hold);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m, av, bv;
    int          w, seen;

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a13 = '0; b13 = '0;
    repeat (2) @(negedge clk);
    check("reset/in_ready", 32'(in_ready[0]), 32'd1);
    check("reset/out_valid", 32'(out_valid[0]), 32'd0);
    check("reset/busy", 32'(busy[0]), 32'd0);
    check("reset/diff", 32'(diff8), 32'd0);
    check("reset/borrow", 32'(borrow[0]), 32'd0);
    rst = 1'b0;

    run_op(0, 16'h5A, 16'h3C, 16'h1E, 1'b0, 0, 1'b0, "basic");
    run_op(0, 16'h00, 16'h01, 16'hFF, 1'b1, 0, 1'b0, "wrap0");
    run_op(0, 16'h80, 16'hFF, 16'h81, 1'b1, 1, 1'b0, "wrap1");
    run_op(0, 16'hFF, 16'hFF, 16'h00, 1'b0, 0, 1'b0, "equal");
    run_op(0, 16'h00, 16'h00, 16'h00, 1'b0, 0, 1'b0, "zero");
    run_op(0, 16'hC7, 16'h2E, 16'h99, 1'b0, 5, 1'b1, "backpressure");
    run_op(0, 16'h01, 16'h02, 16'hFF, 1'b1, 0, 1'b0, "after_probe");

    // Reset lands on the third RUN edge: the operation must vanish
    @(negedge clk);
    drive(0, 1'b1, 16'h33, 16'h11);
    @(negedge clk);
    drive(0, 1'b0, 16'h00, 16'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid/in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_mid/busy", 32'(busy[0]), 32'd0);
    check("rst_mid/out_valid", 32'(out_valid[0]), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1;
    end
    check("rst_mid/no_result", 32'(seen), 32'd0);
    $display("op rst_mid a=0x33 b=0x11 discarded");
    run_op(0, 16'h10, 16'h01, 16'h0F, 1'b0, 0, 1'b0, "post_reset");

    run_op(1, 16'h0, 16'h0, 16'h0, 1'b0, 0, 1'b0, "w1_00");
    run_op(1, 16'h0, 16'h1, 16'h1, 1'b1, 0, 1'b0, "w1_01");
    run_op(1, 16'h1, 16'h0, 16'h1, 1'b0, 1, 1'b0, "w1_10");
    run_op(1, 16'h1, 16'h1, 16'h0, 1'b0, 0, 1'b0, "w1_11");

    for (int s = 0; s <= 2; s += 2) begin
      w = wof(s);
      m = 16'((32'd1 << w) - 1);
      for (int i = 0; i < 200; i++) begin
        av = 16'($urandom) & m;
        bv = 16'($urandom) & m;
        run_op(s, av, bv, (av - bv) & m, av < bv, int'($urandom_range(0, 3)), 1'b0, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
